ddrwr_arb: RTL and testbench

Round-robin arbiter sharing the single ddr_intf write channel (command plus data) among REQ_NUM write requesters: save_mtxreg_ctrl and the other HPU store paths. It grants one requester at a time and holds the grant from command issue until that requester's last data beat is accepted. It also checks burst length against the commanded wlen. It sits between the requester controllers and ddr_intf, with no data storage of its own.

---
 rtl/ddrwr_arb.sv | 156 +++++++++++++++
 tb/tb_ddrwr_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddrwr_arb.sv
// Round-robin arbiter sharing the ddr_intf write channel (command + data) among REQ_NUM requesters.
// Grant is held from command issue until the owner's last data beat; burst length is checked.
module ddrwr_arb #(
    parameter int unsigned REQ_NUM          = 4,
    parameter int unsigned REQ_IDX_WTH      = 2,
    parameter int unsigned DDRIF_ADDR_WTH   = 26,
    parameter int unsigned DDRIF_ALEN_WTH   = 16,
    parameter int unsigned DDRIF_DATA_WTH   = 512,
    parameter int unsigned DDRIF_DSTROB_WTH = DDRIF_DATA_WTH / 8
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [REQ_NUM*DDRIF_ADDR_WTH-1:0]     req__waddr_i,
    input  logic [REQ_NUM*DDRIF_ALEN_WTH-1:0]     req__wlen_i,
    input  logic [REQ_NUM-1:0]                    req__wcmd_vld_i,
    output logic [REQ_NUM-1:0]                    req__wcmd_rdy_o,
    input  logic [REQ_NUM*DDRIF_DATA_WTH-1:0]     req__wdata_i,
    input  logic [REQ_NUM*DDRIF_DSTROB_WTH-1:0]   req__wdata_strob_i,
    input  logic [REQ_NUM-1:0]                    req__wdata_last_i,
    input  logic [REQ_NUM-1:0]                    req__wdata_vld_i,
    output logic [REQ_NUM-1:0]                    req__wdata_rdy_o,
    output logic [DDRIF_ADDR_WTH-1:0]             arb_ddrintf__waddr_o,
    output logic [DDRIF_ALEN_WTH-1:0]             arb_ddrintf__wlen_o,
    output logic                                  arb_ddrintf__wcmd_vld_o,
    input  logic                                  arb_ddrintf__wcmd_rdy_i,
    output logic [DDRIF_DATA_WTH-1:0]             arb_ddrintf__wdata_o,
    output logic [DDRIF_DSTROB_WTH-1:0]           arb_ddrintf__wdata_strob_o,
    output logic                                  arb_ddrintf__wdata_last_o,
    output logic                                  arb_ddrintf__wdata_vld_o,
    input  logic                                  arb_ddrintf__wdata_rdy_i,
    output logic [REQ_NUM-1:0]                    arb__grant_o,
    output logic                                  arb__err_o
);

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e                    state_q, state_d;
    logic [REQ_IDX_WTH-1:0]    rr_ptr_q, rr_ptr_d;
    logic [REQ_IDX_WTH-1:0]    gnt_idx_q, gnt_idx_d;
    logic [DDRIF_ALEN_WTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [DDRIF_ALEN_WTH-1:0] wlen_q, wlen_d;
    logic                      err_q, err_d;

    logic [DDRIF_ADDR_WTH-1:0]   waddr_arr [REQ_NUM];
    logic [DDRIF_ALEN_WTH-1:0]   wlen_arr  [REQ_NUM];
    logic [DDRIF_DATA_WTH-1:0]   wdata_arr [REQ_NUM];
    logic [DDRIF_DSTROB_WTH-1:0] strob_arr [REQ_NUM];
    logic [REQ_IDX_WTH-1:0]      cand_idx  [REQ_NUM];
    logic [REQ_NUM-1:0]          cand_vld;
    logic                        found;
    logic [REQ_IDX_WTH-1:0]      win_idx;

    // cand_idx[g] is the g-th requester visited when searching circularly from rr_ptr
    for (genvar g = 0; g < REQ_NUM; g++) begin : g_req
        assign waddr_arr[g] = req__waddr_i[g*DDRIF_ADDR_WTH +: DDRIF_ADDR_WTH];
        assign wlen_arr[g]  = req__wlen_i[g*DDRIF_ALEN_WTH +: DDRIF_ALEN_WTH];
        assign wdata_arr[g] = req__wdata_i[g*DDRIF_DATA_WTH +: DDRIF_DATA_WTH];
        assign strob_arr[g] = req__wdata_strob_i[g*DDRIF_DSTROB_WTH +: DDRIF_DSTROB_WTH];
        assign cand_idx[g]  = REQ_IDX_WTH'((32'(rr_ptr_q) + 32'(g)) % REQ_NUM);
        assign cand_vld[g]  = req__wcmd_vld_i[cand_idx[g]];
    end

    always_comb begin
        found   = 1'b0;
        win_idx = rr_ptr_q;
        for (int i = 0; i < int'(REQ_NUM); i++) begin
            if (!found && cand_vld[i]) begin
                found   = 1'b1;
                win_idx = cand_idx[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_idx_d  = gnt_idx_q;
        beat_cnt_d = beat_cnt_q;
        wlen_d     = wlen_q;
        err_d      = err_q;

        req__wcmd_rdy_o            = '0;
        req__wdata_rdy_o           = '0;
        arb_ddrintf__waddr_o       = '0;
        arb_ddrintf__wlen_o        = '0;
        arb_ddrintf__wcmd_vld_o    = 1'b0;
        arb_ddrintf__wdata_o       = '0;
        arb_ddrintf__wdata_strob_o = '0;
        arb_ddrintf__wdata_last_o  = 1'b0;
        arb_ddrintf__wdata_vld_o   = 1'b0;
        arb__grant_o               = '0;

        unique case (state_q)
            StIdle: begin
                if (found) begin
                    gnt_idx_d = win_idx;
                    state_d   = StCmd;
                end
            end
            StCmd: begin
                arb__grant_o[gnt_idx_q]    = 1'b1;
                arb_ddrintf__waddr_o       = waddr_arr[gnt_idx_q];
                arb_ddrintf__wlen_o        = wlen_arr[gnt_idx_q];
                arb_ddrintf__wcmd_vld_o    = req__wcmd_vld_i[gnt_idx_q];
                req__wcmd_rdy_o[gnt_idx_q] = arb_ddrintf__wcmd_rdy_i;
                if (arb_ddrintf__wcmd_vld_o && arb_ddrintf__wcmd_rdy_i) begin
                    wlen_d     = wlen_arr[gnt_idx_q];
                    beat_cnt_d = '0;
                    state_d    = StData;
                end
            end
            StData: begin
                arb__grant_o[gnt_idx_q]     = 1'b1;
                arb_ddrintf__wdata_o        = wdata_arr[gnt_idx_q];
                arb_ddrintf__wdata_strob_o  = strob_arr[gnt_idx_q];
                arb_ddrintf__wdata_last_o   = req__wdata_last_i[gnt_idx_q];
                arb_ddrintf__wdata_vld_o    = req__wdata_vld_i[gnt_idx_q];
                req__wdata_rdy_o[gnt_idx_q] = arb_ddrintf__wdata_rdy_i;
                if (arb_ddrintf__wdata_vld_o && arb_ddrintf__wdata_rdy_i) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    // Burst always ends on the requester's last, even if the length disagrees
                    if (arb_ddrintf__wdata_last_o) begin
                        if (beat_cnt_q != wlen_q) err_d = 1'b1;
                        state_d  = StIdle;
                        rr_ptr_d = (gnt_idx_q == REQ_IDX_WTH'(REQ_NUM - 1)) ? '0 :
                                   gnt_idx_q + 1'b1;
                    end else if (beat_cnt_q == wlen_q) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign arb__err_o = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            beat_cnt_q <= '0;
            wlen_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            beat_cnt_q <= beat_cnt_d;
            wlen_q     <= wlen_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_ddrwr_arb.sv
// Directed bench for ddrwr_arb: round-robin order, command/data forwarding, backpressure,
// length errors and reset mid-burst.
module tb_ddrwr_arb;

    localparam int NR = 4;
    localparam int AW = 26;
    localparam int LW = 16;
    localparam int DW = 32;
    localparam int SW = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NR*AW-1:0]   waddr = '0;
    logic [NR*LW-1:0]   wlen = '0;
    logic [NR-1:0]      cmd_vld = '0;
    logic [NR-1:0]      cmd_rdy_o;
    logic [NR*DW-1:0]   wdata = '0;
    logic [NR*SW-1:0]   strob = '0;
    logic [NR-1:0]      dlast = '0;
    logic [NR-1:0]      dvld = '0;
    logic [NR-1:0]      drdy_o;
    logic [AW-1:0]      o_waddr;
    logic [LW-1:0]      o_wlen;
    logic               o_cmd_vld;
    logic               ddr_cmd_rdy = 1'b1;
    logic [DW-1:0]      o_wdata;
    logic [SW-1:0]      o_strob;
    logic               o_last;
    logic               o_dvld;
    logic               ddr_data_rdy = 1'b1;
    logic [NR-1:0]      grant;
    logic               err;

    int total = 0;
    int bad   = 0;

    ddrwr_arb #(
        .REQ_NUM         (NR),
        .REQ_IDX_WTH     (2),
        .DDRIF_ADDR_WTH  (AW),
        .DDRIF_ALEN_WTH  (LW),
        .DDRIF_DATA_WTH  (DW),
        .DDRIF_DSTROB_WTH(SW)
    ) u_dut (
        .clk_i                     (clk),
        .rst_i                     (rst),
        .req__waddr_i              (waddr),
        .req__wlen_i               (wlen),
        .req__wcmd_vld_i           (cmd_vld),
        .req__wcmd_rdy_o           (cmd_rdy_o),
        .req__wdata_i              (wdata),
        .req__wdata_strob_i        (strob),
        .req__wdata_last_i         (dlast),
        .req__wdata_vld_i          (dvld),
        .req__wdata_rdy_o          (drdy_o),
        .arb_ddrintf__waddr_o      (o_waddr),
        .arb_ddrintf__wlen_o       (o_wlen),
        .arb_ddrintf__wcmd_vld_o   (o_cmd_vld),
        .arb_ddrintf__wcmd_rdy_i   (ddr_cmd_rdy),
        .arb_ddrintf__wdata_o      (o_wdata),
        .arb_ddrintf__wdata_strob_o(o_strob),
        .arb_ddrintf__wdata_last_o (o_last),
        .arb_ddrintf__wdata_vld_o  (o_dvld),
        .arb_ddrintf__wdata_rdy_i  (ddr_data_rdy),
        .arb__grant_o              (grant),
        .arb__err_o                (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NR-1:0] onehot(input int k);
        logic [NR-1:0] one;
        one = 1;
        return one << k;
    endfunction

    task automatic set_cmd(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
        waddr[k*AW +: AW] = a;
        wlen[k*LW +: LW]  = l;
        cmd_vld[k]        = 1'b1;
    endtask

    task automatic expect_cmd(input int k, input logic [AW-1:0] a, input logic [LW-1:0] l);
        #1;
        chk("cmd_grant", grant, onehot(k));
        chk("cmd_vld", o_cmd_vld, 1);
        chk("cmd_waddr", o_waddr, a);
        chk("cmd_wlen", o_wlen, l);
        chk("cmd_rdy", cmd_rdy_o, ddr_cmd_rdy ? onehot(k) : '0);
        chk("cmd_dvld_quiet", o_dvld, 0);
    endtask

    function automatic logic [DW-1:0] beat_val(input int k, input int i);
        return 32'hD000_0000 | 32'(k << 8) | 32'(i);
    endfunction

    // Sends n beats from requester k at full rate; last flagged on the final beat if last_en
    task automatic beats(input int k, input int n, input bit last_en);
        for (int i = 0; i < n; i++) begin
            wdata[k*DW +: DW] = beat_val(k, i);
            strob[k*SW +: SW] = SW'(i + 1);
            dlast[k]          = last_en && (i == n - 1);
            dvld[k]           = 1'b1;
            ddr_data_rdy      = 1'b1;
            #1;
            chk("data_val", o_wdata, beat_val(k, i));
            chk("data_strob", o_strob, SW'(i + 1));
            chk("data_last", o_last, last_en && (i == n - 1));
            chk("data_rdy", drdy_o, onehot(k));
            chk("data_grant", grant, onehot(k));
            chk("data_cmd_quiet", {o_cmd_vld, o_waddr}, 0);
            tick();
        end
        dvld[k]  = 1'b0;
        dlast[k] = 1'b0;
    endtask

    // Same, but ddr_intf ready toggles low/high so each beat takes two cycles
    task automatic beats_bp(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            wdata[k*DW +: DW] = beat_val(k, i);
            strob[k*SW +: SW] = SW'(i + 1);
            dlast[k]          = (i == n - 1);
            dvld[k]           = 1'b1;
            ddr_data_rdy      = 1'b0;
            #1;
            chk("bp_rdy_low", drdy_o, 0);
            chk("bp_vld", o_dvld, 1);
            tick();
            ddr_data_rdy = 1'b1;
            #1;
            chk("bp_rdy_high", drdy_o, onehot(k));
            chk("bp_data", o_wdata, beat_val(k, i));
            chk("bp_last", o_last, i == n - 1);
            tick();
        end
        dvld[k]  = 1'b0;
        dlast[k] = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_vld", o_cmd_vld, 0);
        chk("rst_dvld", o_dvld, 0);
        chk("rst_rdys", {cmd_rdy_o, drdy_o}, 0);

        // Contention req0/req2 with rr_ptr=0: req0 first (one beat), then req2
        set_cmd(0, 26'h40, 16'd0);
        set_cmd(2, 26'h80, 16'd1);
        #1;
        chk("idle_cmd_rdy", cmd_rdy_o, 0);
        chk("idle_grant", grant, 0);
        tick();
        expect_cmd(0, 26'h40, 16'd0);
        tick();
        cmd_vld[0] = 1'b0;
        beats(0, 1, 1'b1);
        #1;
        chk("bubble_grant", grant, 0);
        chk("bubble_loser_rdy", cmd_rdy_o, 0);
        tick();
        expect_cmd(2, 26'h80, 16'd1);
        tick();
        cmd_vld[2] = 1'b0;
        beats(2, 2, 1'b1);
        #1;
        chk("cont_err", err, 0);

        // Single req1 with 5 cycles of command backpressure, then 4 beats
        ddr_cmd_rdy = 1'b0;
        set_cmd(1, 26'h100, 16'd3);
        tick();
        for (int c = 0; c < 5; c++) begin
            expect_cmd(1, 26'h100, 16'd3);
            tick();
        end
        ddr_cmd_rdy = 1'b1;
        expect_cmd(1, 26'h100, 16'd3);
        tick();
        cmd_vld[1] = 1'b0;
        beats(1, 4, 1'b1);
        #1;
        chk("single_err", err, 0);
        chk("single_idle_grant", grant, 0);

        // Second contention with rr_ptr=2: req2 first, data ready toggling over wlen=7
        set_cmd(0, 26'h200, 16'd3);
        set_cmd(2, 26'h300, 16'd7);
        tick();
        expect_cmd(2, 26'h300, 16'd7);
        tick();
        cmd_vld[2] = 1'b0;
        beats_bp(2, 8);
        #1;
        chk("bp_idle_grant", grant, 0);
        chk("bp_err", err, 0);
        tick();
        // req0 wlen=3 but last on beat 1
        expect_cmd(0, 26'h200, 16'd3);
        tick();
        cmd_vld[0] = 1'b0;
        beats(0, 2, 1'b1);
        #1;
        chk("short_err", err, 1);
        chk("short_idle", grant, 0);

        // Reset during DATA after two beats of eight
        set_cmd(3, 26'h3f0, 16'd7);
        tick();
        expect_cmd(3, 26'h3f0, 16'd7);
        tick();
        cmd_vld[3] = 1'b0;
        beats(3, 2, 1'b0);
        wdata[3*DW +: DW] = beat_val(3, 2);
        dvld[3] = 1'b1;
        rst = 1'b1;
        #1;
        chk("pre_rst_grant", grant, onehot(3));
        tick();
        rst = 1'b0;
        dvld[3] = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_dvld", o_dvld, 0);
        chk("mid_rst_rdys", {cmd_rdy_o, drdy_o}, 0);
        chk("mid_rst_cmd_vld", o_cmd_vld, 0);
        chk("mid_rst_err", err, 0);

        // rr_ptr back at 0: req0 beats req1; then req1 wlen=1 with no last on beat 1
        set_cmd(0, 26'h10, 16'd0);
        set_cmd(1, 26'h20, 16'd1);
        tick();
        expect_cmd(0, 26'h10, 16'd0);
        tick();
        cmd_vld[0] = 1'b0;
        beats(0, 1, 1'b1);
        #1;
        chk("post_rst_err", err, 0);
        tick();
        expect_cmd(1, 26'h20, 16'd1);
        tick();
        cmd_vld[1] = 1'b0;
        beats(1, 3, 1'b1);
        #1;
        chk("long_err", err, 1);
        chk("long_idle", grant, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
